// File: rtl/axicb_pkg.sv
// Shared helpers for the AXI crossbar master-side ID tracking.
package axicb_pkg;

  localparam int unsigned ID_W_MAX = 32;

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic logic [ID_W_MAX-1:0] slot_idx(input logic [ID_W_MAX-1:0] id,
                                                   input logic [ID_W_MAX-1:0] mask);
    return id ^ mask;
  endfunction

endpackage

// File: rtl/axicb_id_slot.sv
// One ID slot: outstanding count plus the target/misroute binding it was opened with.
module axicb_id_slot
  import axicb_pkg::*;
#(
  parameter int unsigned CW     = 3,
  parameter int unsigned MAX    = 4,
  parameter int unsigned SLV_NB = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              inc,
  input  logic              dec,
  input  logic [SLV_NB-1:0] a_ix,
  input  logic              a_mr,
  output logic              idle,
  output logic              match
);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SLV_NB-1:0] tgt_q, tgt_d;
  logic              mr_q, mr_d;

  always_comb begin
    cnt_d = cnt_q;
    tgt_d = tgt_q;
    mr_d  = mr_q;
    if (inc && !dec && (cnt_q < CW'(MAX))) begin
      cnt_d = cnt_q + CW'(1);
      // Binding is captured only when the slot opens; later requests must match it.
      if (cnt_q == '0) begin
        tgt_d = a_ix;
        mr_d  = a_mr;
      end
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt_q <= '0;
      tgt_q <= '0;
      mr_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tgt_q <= tgt_d;
      mr_q  <= mr_d;
    end
  end

  assign idle  = (cnt_q == '0);
  assign match = (tgt_q == a_ix) && (mr_q == a_mr);

endmodule

// File: rtl/axicb_mst_id_tracker.sv
// Master-side outstanding-ID tracker: blocks requests that would reorder an ID across slaves.
module axicb_mst_id_tracker
  import axicb_pkg::*;
#(
  parameter int unsigned          AXI_ID_W        = 8,
  parameter int unsigned          SLV_NB          = 4,
  parameter int unsigned          MST_OSTDREQ_NUM = 4,
  parameter logic [AXI_ID_W-1:0]  MST_ID_MASK     = '0
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  input  logic                                 a_valid,
  output logic                                 a_ready,
  input  logic [AXI_ID_W-1:0]                  a_id,
  input  logic [SLV_NB-1:0]                    a_ix,
  input  logic                                 a_mr,
  output logic                                 o_valid,
  input  logic                                 o_ready,
  output logic [AXI_ID_W-1:0]                  o_id,
  output logic [SLV_NB-1:0]                    o_ix,
  output logic                                 o_mr,
  input  logic                                 c_end,
  input  logic [AXI_ID_W-1:0]                  c_id,
  output logic [$clog2(MST_OSTDREQ_NUM+1)-1:0] ostd_cnt,
  output logic                                 id_err,
  output logic                                 cpl_err
);

  localparam int unsigned CW  = cnt_w(MST_OSTDREQ_NUM);
  localparam int unsigned NS  = (MST_OSTDREQ_NUM < 2) ? 1 : MST_OSTDREQ_NUM;
  localparam int unsigned IXW = (NS > 1) ? $clog2(NS) : 1;

  logic [ID_W_MAX-1:0] a_idx, c_idx;
  logic [IXW-1:0]      a_sel, c_sel;
  logic                a_in_rng, c_in_rng;
  logic [NS-1:0]       idle, match, inc_v, dec_v;
  logic                a_idle, a_match, c_idle;
  logic                allow, accept, c_ok, same;
  logic [CW-1:0]       ostd_q, ostd_d;
  logic                id_err_q, id_err_d, cpl_err_q, cpl_err_d;

  assign a_idx    = slot_idx(ID_W_MAX'(a_id), ID_W_MAX'(MST_ID_MASK));
  assign c_idx    = slot_idx(ID_W_MAX'(c_id), ID_W_MAX'(MST_ID_MASK));
  assign a_in_rng = (NS == 1) || (a_idx < ID_W_MAX'(NS));
  assign c_in_rng = (NS == 1) || (c_idx < ID_W_MAX'(NS));
  assign a_sel    = (NS == 1) ? '0 : a_idx[IXW-1:0];
  assign c_sel    = (NS == 1) ? '0 : c_idx[IXW-1:0];

  // Mux by compare so a non-power-of-two slot count never indexes past the array.
  always_comb begin
    a_idle  = 1'b0;
    a_match = 1'b0;
    c_idle  = 1'b1;
    for (int unsigned g = 0; g < NS; g++) begin
      if (IXW'(g) == a_sel) begin
        a_idle  = idle[g];
        a_match = match[g];
      end
      if (IXW'(g) == c_sel) c_idle = idle[g];
    end
  end

  assign allow   = (ostd_q < CW'(MST_OSTDREQ_NUM)) && a_in_rng && (a_idle || a_match);
  assign o_valid = aresetn && a_valid && allow;
  assign a_ready = aresetn && o_ready && allow;
  assign o_id    = a_id;
  assign o_ix    = a_ix;
  assign o_mr    = a_mr;

  assign accept = o_valid && o_ready;
  assign c_ok   = c_end && c_in_rng && !c_idle;
  assign same   = accept && c_ok && (a_sel == c_sel);

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int unsigned g = 0; g < NS; g++) begin
      inc_v[g] = accept && !same && (IXW'(g) == a_sel);
      dec_v[g] = c_ok && !same && (IXW'(g) == c_sel);
    end
  end

  for (genvar g = 0; g < NS; g++) begin : g_slot
    axicb_id_slot #(
      .CW     (CW),
      .MAX    (MST_OSTDREQ_NUM),
      .SLV_NB (SLV_NB)
    ) u_slot (
      .aclk    (aclk),
      .aresetn (aresetn),
      .inc     (inc_v[g]),
      .dec     (dec_v[g]),
      .a_ix    (a_ix),
      .a_mr    (a_mr),
      .idle    (idle[g]),
      .match   (match[g])
    );
  end

  always_comb begin
    ostd_d = ostd_q;
    if (accept && !c_ok)      ostd_d = ostd_q + CW'(1);
    else if (c_ok && !accept) ostd_d = ostd_q - CW'(1);
    id_err_d  = id_err_q  || (a_valid && !a_in_rng);
    cpl_err_d = cpl_err_q || (c_end && !c_ok);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ostd_q    <= '0;
      id_err_q  <= 1'b0;
      cpl_err_q <= 1'b0;
    end else begin
      ostd_q    <= ostd_d;
      id_err_q  <= id_err_d;
      cpl_err_q <= cpl_err_d;
    end
  end

  assign ostd_cnt = ostd_q;
  assign id_err   = id_err_q;
  assign cpl_err  = cpl_err_q;

endmodule

// File: tb/tb_axicb_mst_id_tracker.sv
// Table-driven bench for axicb_mst_id_tracker with a queue of expected per-cycle results.
module tb_axicb_mst_id_tracker;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic       a_valid, a_ready, a_mr, o_valid, o_ready, o_mr, c_end, id_err, cpl_err;
  logic [7:0] a_id, o_id, c_id;
  logic [3:0] a_ix, o_ix;
  logic [2:0] ostd_cnt;

  always #5 aclk = ~aclk;

  axicb_mst_id_tracker dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_id     (a_id),
    .a_ix     (a_ix),
    .a_mr     (a_mr),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_id     (o_id),
    .o_ix     (o_ix),
    .o_mr     (o_mr),
    .c_end    (c_end),
    .c_id     (c_id),
    .ostd_cnt (ostd_cnt),
    .id_err   (id_err),
    .cpl_err  (cpl_err)
  );

  typedef struct {
    logic       rstb;
    logic       v;
    logic [7:0] id;
    logic [3:0] ix;
    logic       mr;
    logic       rdy;
    logic       ce;
    logic [7:0] cid;
    logic       ov;
    logic       ar;
    int         ostd;
    logic       ie;
    logic       cpe;
  } vec_t;

  localparam int NV = 30;
  vec_t tbl [NV];
  vec_t exp_q [$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   row    = 0;

  function automatic vec_t mk(logic rstb, logic v, int id, int ix, logic mr, logic rdy,
                              logic ce, int cid, logic ov, logic ar, int ostd,
                              logic ie, logic cpe);
    vec_t t;
    t.rstb = rstb; t.v = v; t.id = 8'(id); t.ix = 4'(ix); t.mr = mr; t.rdy = rdy;
    t.ce = ce; t.cid = 8'(cid); t.ov = ov; t.ar = ar; t.ostd = ostd; t.ie = ie; t.cpe = cpe;
    return t;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s row %0d: got %0d expected %0d", nm, row, act, exp);
  endtask

  task automatic drive(input vec_t t);
    aresetn = t.rstb; a_valid = t.v; a_id = t.id; a_ix = t.ix; a_mr = t.mr;
    o_ready = t.rdy; c_end = t.ce; c_id = t.cid;
  endtask

  task automatic apply(input vec_t t);
    vec_t e;
    @(posedge aclk); #1;
    drive(t);
    exp_q.push_back(t);
    @(negedge aclk);
    e = exp_q.pop_front();
    chk("o_valid",  int'(o_valid),  int'(e.ov));
    chk("a_ready",  int'(a_ready),  int'(e.ar));
    chk("ostd_cnt", int'(ostd_cnt), e.ostd);
    chk("id_err",   int'(id_err),   int'(e.ie));
    chk("cpl_err",  int'(cpl_err),  int'(e.cpe));
    if (e.v) begin
      chk("o_id", int'(o_id), int'(e.id));
      chk("o_ix", int'(o_ix), int'(e.ix));
      chk("o_mr", int'(o_mr), int'(e.mr));
    end
  endtask

  initial begin
    //            rstb v id ix mr rdy ce cid  ov ar ostd ie cpe
    tbl[0]  = mk(0, 1, 7, 1, 0, 1, 1, 2,  0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 1, 0, 1, 0, 0,  1, 1, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0);
    tbl[3]  = mk(1, 1, 0, 2, 0, 1, 0, 0,  0, 0, 1, 0, 0);
    tbl[4]  = mk(1, 1, 0, 2, 0, 1, 1, 0,  0, 0, 1, 0, 0);
    tbl[5]  = mk(1, 1, 0, 2, 0, 1, 0, 0,  1, 1, 0, 0, 0);
    tbl[6]  = mk(1, 1, 0, 2, 0, 0, 0, 0,  1, 0, 1, 0, 0);
    tbl[7]  = mk(1, 1, 1, 1, 0, 1, 0, 0,  1, 1, 1, 0, 0);
    tbl[8]  = mk(1, 1, 1, 1, 0, 1, 0, 0,  1, 1, 2, 0, 0);
    tbl[9]  = mk(1, 1, 1, 1, 0, 1, 1, 1,  1, 1, 3, 0, 0);
    tbl[10] = mk(1, 1, 1, 4, 0, 1, 0, 0,  0, 0, 3, 0, 0);
    tbl[11] = mk(1, 0, 0, 0, 0, 0, 1, 1,  0, 0, 3, 0, 0);
    tbl[12] = mk(1, 0, 0, 0, 0, 0, 1, 1,  0, 0, 2, 0, 0);
    tbl[13] = mk(1, 1, 1, 4, 0, 1, 0, 0,  1, 1, 1, 0, 0);
    tbl[14] = mk(1, 0, 0, 0, 0, 0, 1, 2,  0, 0, 2, 0, 0);
    tbl[15] = mk(1, 1, 7, 1, 0, 1, 0, 0,  0, 0, 2, 0, 1);
    tbl[16] = mk(1, 1, 2, 1, 1, 1, 0, 0,  1, 1, 2, 1, 1);
    tbl[17] = mk(1, 1, 2, 1, 0, 1, 0, 0,  0, 0, 3, 1, 1);
    tbl[18] = mk(1, 1, 3, 8, 0, 1, 0, 0,  1, 1, 3, 1, 1);
    tbl[19] = mk(1, 1, 3, 8, 0, 1, 0, 0,  0, 0, 4, 1, 1);
    tbl[20] = mk(1, 1, 3, 8, 0, 1, 1, 0,  0, 0, 4, 1, 1);
    tbl[21] = mk(1, 1, 3, 8, 0, 1, 0, 0,  1, 1, 3, 1, 1);
    tbl[22] = mk(1, 0, 0, 0, 0, 0, 1, 3,  0, 0, 4, 1, 1);
    tbl[23] = mk(1, 1, 0, 1, 0, 1, 1, 2,  1, 1, 3, 1, 1);
    tbl[24] = mk(1, 1, 2, 4, 0, 1, 0, 0,  1, 1, 3, 1, 1);
    tbl[25] = mk(1, 0, 0, 0, 0, 0, 1, 2,  0, 0, 4, 1, 1);
    tbl[26] = mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 3, 1, 1);
    tbl[27] = mk(0, 1, 1, 2, 0, 1, 0, 0,  0, 0, 3, 1, 1);
    tbl[28] = mk(1, 1, 1, 2, 0, 1, 0, 0,  1, 1, 0, 0, 0);
    tbl[29] = mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0);

    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge aclk);

    for (int i = 0; i < NV; i++) begin
      row = i;
      apply(tbl[i]);
    end

    // Slot1 now holds one request bound to 'b0010; a conflicting request waits
    // for the completion and is accepted the cycle after it.
    row = 100;
    for (int i = 0; i < 4; i++) begin
      @(posedge aclk); #1;
      drive(mk(1, 1, 1, 4, 0, 1, (i == 2), 1, 0, 0, 0, 0, 0));
      @(negedge aclk);
      row = 100 + i;
      chk("wait_o_valid", int'(o_valid), (i == 3) ? 1 : 0);
      chk("wait_a_ready", int'(a_ready), (i == 3) ? 1 : 0);
    end
    @(posedge aclk); #1;
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge aclk);
    row = 104;
    chk("wait_ostd", int'(ostd_cnt), 1);
    chk("wait_cpl_err", int'(cpl_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axicb_mst_id_tracker.md
AXICB_MST_ID_TRACKER -- requirements
Module: axicb_mst_id_tracker

Interface
REQ-001 SHALL have parameter AXI_ID_W, default 8: ID width in bits.
REQ-002 SHALL have parameter SLV_NB, default 4: number of slaves; width of the one-hot target index.
REQ-003 SHALL have parameter MST_OSTDREQ_NUM, default 4: max outstanding requests; also the number of ID slots.
REQ-004 SHALL have parameter MST_ID_MASK, width AXI_ID_W, default 'h00: XORed with an ID to get its unmasked slot index.
REQ-005 SHALL have port aclk, input, 1: clock.
REQ-006 SHALL have port aresetn, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have address-in ports: a_valid in 1, a_ready out 1, a_id in AXI_ID_W, a_ix in SLV_NB (one-hot target), a_mr in 1 (misrouted).
REQ-008 SHALL have address-out ports: o_valid out 1, o_ready in 1, o_id out AXI_ID_W, o_ix out SLV_NB, o_mr out 1.
REQ-009 SHALL have completion-retire ports: c_end in 1 (last beat accepted, registered upstream) and c_id in AXI_ID_W.
REQ-010 SHALL have status outputs: ostd_cnt out $clog2(MST_OSTDREQ_NUM+1) (total outstanding), id_err out 1, cpl_err out 1 (both sticky).

Function
REQ-011 SHALL hold per slot: cnt (0..MST_OSTDREQ_NUM), tgt (SLV_NB), mr (1); slot state IDLE when cnt==0, ACTIVE otherwise.
REQ-012 SHALL compute slot index = (id ^ MST_ID_MASK); if MST_OSTDREQ_NUM<2, one slot and every ID maps to slot 0.
REQ-013 SHALL define allow = (ostd_cnt < MST_OSTDREQ_NUM) AND (slot IDLE OR (tgt==a_ix AND mr==a_mr)) AND (slot index < MST_OSTDREQ_NUM).
REQ-014 SHALL drive the address path combinationally with zero latency:
  - o_valid = a_valid & allow
  - a_ready = o_ready & allow
  - o_id/o_ix/o_mr = a_id/a_ix/a_mr
REQ-015 SHALL, on o_valid & o_ready, increment the slot cnt and ostd_cnt; on an IDLE->ACTIVE transition it SHALL load tgt=a_ix and mr=a_mr.
REQ-016 SHALL, on c_end, decrement the cnt of slot (c_id ^ MST_ID_MASK) and decrement ostd_cnt; ACTIVE->IDLE when cnt reaches 0.
REQ-017 SHALL, when an accept and a c_end hit the same slot in one cycle, leave that slot's cnt, tgt and mr unchanged, and leave ostd_cnt unchanged.
REQ-018 SHALL, when an accept and a c_end hit different slots in one cycle, update both slots and leave ostd_cnt unchanged.
REQ-019 SHALL, on c_end to an IDLE or out-of-range slot, make no counter change and set cpl_err.
REQ-020 SHALL, while a_valid presents an out-of-range slot index, block the request and set id_err; no counter changes.
REQ-021 SHALL NOT let a_ready depend on o_valid; it depends only on o_ready and registered slot state.
REQ-022 SHALL never wrap any counter: accept at MST_OSTDREQ_NUM and decrement at 0 are both prevented.

Reset
REQ-023 SHALL, on aresetn low at a rising aclk edge, clear all cnt, tgt, mr, ostd_cnt, id_err and cpl_err.
REQ-024 SHALL drive o_valid=0 and a_ready=0 during reset; after reset, o_valid follows a_valid and a_ready follows o_ready per REQ-014.
REQ-025 SHALL, when reset hits mid-operation, drop all outstanding tracking; the environment resets upstream and downstream together.

Structure
REQ-026 SHALL take the slot index function and the counter width constant from shared package axicb_pkg.
REQ-027 SHALL implement per-slot state in sub-module axicb_id_slot (cnt/tgt/mr, inc/dec/load, idle and match outputs), instantiated MST_OSTDREQ_NUM times.

Verification
REQ-028 SHALL cover: reset, then ID 0 to slave 'b0001 with o_ready=1 -> accepted same cycle; slot0 cnt=1, ostd_cnt=1.
REQ-029 SHALL cover: slot0 ACTIVE on 'b0001, new ID 0 to 'b0010 -> a_ready=0 and o_valid=0 until c_end with c_id=0, then accepted in the following cycle.
REQ-030 SHALL cover: four accepts on IDs 0..3 -> fifth request blocked; one c_end -> fifth accepted; ostd_cnt peaks at 4 and never reaches 5.
REQ-031 SHALL cover: same-cycle accept and c_end on ID 1 with cnt=2 -> cnt stays 2, ostd_cnt unchanged, tgt unchanged.
REQ-032 SHALL cover: c_end with c_id=2 while slot2 IDLE -> cpl_err=1, counters unchanged; a_id=7 with MST_OSTDREQ_NUM=4 -> blocked, id_err=1.
